// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the execute-stage multiply sequencer.
package mult_seq_ctrl_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MULT_CYCLES = WIDTH;
  localparam int unsigned CNT_W       = $clog2(MULT_CYCLES);
  localparam logic [2:0]  ALU_ADD     = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_seq_ctrl_signfix.sv
// Operand magnitudes for signed multiply and conditional negate of the 2W-bit product.
module mult_seq_ctrl_signfix
  import mult_seq_ctrl_pkg::*;
(
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     src_a,
  input  logic [WIDTH-1:0]     src_b,
  input  logic                 neg,
  input  logic [2*WIDTH-1:0]   prod,
  output logic [WIDTH-1:0]     mag_a,
  output logic [WIDTH-1:0]     mag_b,
  output logic [2*WIDTH-1:0]   prod_fix
);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    mag_a    = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b    = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    prod_fix = neg ? -prod : prod;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-and-add multiplier that borrows the shared ALU adder and owns HI/LO.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             MultStartE,
  input  logic             MultSgnE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             MfSelE,
  output logic             ALUGrant,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALUCtrlMult,
  output logic [WIDTH-1:0] HiLoOutE,
  output logic             StallMultE,
  output logic             MultDoneE
);

  mult_state_e         state, state_nxt;
  logic [WIDTH-1:0]    m_q, p_hi, p_lo, hi_q, lo_q;
  logic                neg_q, done_q;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [2*WIDTH-1:0]  prod_fix;
  logic                accept, last, carry;

  mult_seq_ctrl_signfix u_signfix (
    .sgn      (MultSgnE),
    .src_a    (SrcAE),
    .src_b    (SrcBE),
    .neg      (neg_q),
    .prod     ({p_hi, p_lo}),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .prod_fix (prod_fix)
  );

  assign accept = (state == IDLE) && MultStartE && !FlushE;
  assign last   = (cnt == CNT_W'(MULT_CYCLES - 1));
  // Unsigned adder overflow: the sum wrapped below one of its operands.
  assign carry  = (ALUOut < p_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ALUGrant    = 1'b0;
    ALU_A       = '0;
    ALU_B       = '0;
    ALUCtrlMult = ALU_ADD;
    StallMultE  = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        ALUGrant   = 1'b1;
        ALU_A      = p_hi;
        ALU_B      = p_lo[0] ? m_q : '0;
        StallMultE = 1'b1;
        if (last) state_nxt = FIX;
      end
      FIX: begin
        StallMultE = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial product, operand latches and HI/LO result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      unique case (state)
        IDLE: if (accept) begin
          m_q   <= mag_a;
          p_hi  <= '0;
          p_lo  <= mag_b;
          neg_q <= MultSgnE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          cnt   <= '0;
        end
        RUN: begin
          {p_hi, p_lo} <= {carry, ALUOut, p_lo[WIDTH-1:1]};
          cnt          <= cnt + CNT_W'(1);
        end
        FIX:     {hi_q, lo_q} <= prod_fix;
        default: ;
      endcase
    end
  end

  assign HiLoOutE  = MfSelE ? hi_q : lo_q;
  assign MultDoneE = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural ALU adder.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MultStartE = 1'b0, MultSgnE = 1'b0, FlushE = 1'b0, MfSelE;
  logic [31:0] SrcAE = '0, SrcBE = '0, ALUOut, ALU_A, ALU_B, HiLoOutE;
  logic [2:0]  ALUCtrlMult;
  logic        ALUGrant, StallMultE, MultDoneE;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  bit          mon_active = 1'b0;
  logic        mon_sel = 1'b0, stim_sel = 1'b0;

  assign MfSelE = mon_active ? mon_sel : stim_sel;
  assign ALUOut = (ALUCtrlMult == 3'b010) ? ALU_A + ALU_B : 32'h0;

  always #5 clk = ~clk;

  mult_seq_ctrl dut (
    .clk(clk), .rst(rst), .MultStartE(MultStartE), .MultSgnE(MultSgnE),
    .FlushE(FlushE), .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUOut(ALUOut),
    .MfSelE(MfSelE), .ALUGrant(ALUGrant), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALUCtrlMult(ALUCtrlMult), .HiLoOutE(HiLoOutE), .StallMultE(StallMultE),
    .MultDoneE(MultDoneE)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic read_hilo(output logic [63:0] v);
    stim_sel = 1'b0;
    #1 v[31:0] = HiLoOutE;
    stim_sel = 1'b1;
    #1 v[63:32] = HiLoOutE;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of T+34.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input bit timing, input int flush_at);
    if (timing) check("stall_in_accept_cycle", 64'(StallMultE), 64'd0);
    MultStartE = 1'b1; MultSgnE = sgn; SrcAE = a; SrcBE = b;
    exp_q.push_back(exp);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) begin
        MultStartE = 1'b0; SrcAE = 32'hDEAD_BEEF; SrcBE = 32'h1234_5678;
      end
      FlushE = (k == flush_at);
      if (timing) begin
        check($sformatf("stall_k%0d", k), 64'(StallMultE), 64'(k <= 33));
        check($sformatf("done_k%0d", k), 64'(MultDoneE), 64'(k == 34));
        if (k == 1 || k == 33 || k == 34)
          check($sformatf("grant_k%0d", k), 64'(ALUGrant), 64'(k <= 32));
      end
    end
    FlushE = 1'b0;
  endtask

  // Monitor: on every MultDoneE pulse read LO then HI and compare with the queue head.
  initial begin
    logic [63:0] got, exp;
    forever begin
      @(negedge clk);
      if (MultDoneE === 1'b1) begin
        mon_active = 1'b1;
        mon_sel = 1'b0;
        #1 got[31:0] = HiLoOutE;
        mon_sel = 1'b1;
        #1 got[63:32] = HiLoOutE;
        mon_active = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check("hilo_result", got, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    repeat (2) @(negedge clk);
    check("reset_stall", 64'(StallMultE), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_grant", 64'(ALUGrant), 64'd0);
    check("reset_alu_a", 64'(ALU_A), 64'd0);
    check("reset_alu_b", 64'(ALU_B), 64'd0);
    check("reset_done", 64'(MultDoneE), 64'd0);
    check("alu_ctrl", 64'(ALUCtrlMult), 64'd2);
    read_hilo(v);
    check("reset_hilo", v, 64'd0);
    @(negedge clk);

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1, 0);
    do_mult(32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0, 0);
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0, 0);
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 0);
    do_mult(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000, 1'b0, 0);
    do_mult(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0, 0);

    // Flushed start in IDLE must not start anything.
    @(negedge clk);
    MultStartE = 1'b1; FlushE = 1'b1; MultSgnE = 1'b0; SrcAE = 32'd3; SrcBE = 32'd3;
    @(negedge clk);
    MultStartE = 1'b0; FlushE = 1'b0;
    check("flush_idle_stall", 64'(StallMultE), 64'd0);
    repeat (3) @(negedge clk);
    check("flush_idle_stall_later", 64'(StallMultE), 64'd0);
    read_hilo(v);
    check("flush_idle_hilo", v, 64'hFFFF_FFFF_8000_0000);

    // Flush in RUN is ignored.
    @(negedge clk);
    do_mult(32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780, 1'b1, 5);

    // Reset at T+10 aborts the multiply without a done pulse.
    @(negedge clk);
    MultStartE = 1'b1; MultSgnE = 1'b0; SrcAE = 32'd100; SrcBE = 32'd200;
    @(negedge clk);
    MultStartE = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_stall", 64'(StallMultE), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_stall", 64'(StallMultE), 64'd0);
    check("abort_grant", 64'(ALUGrant), 64'd0);
    check("abort_done", 64'(MultDoneE), 64'd0);
    read_hilo(v);
    check("abort_hilo", v, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_stall", 64'(StallMultE), 64'd0);
    do_mult(32'd7, 32'd6, 1'b0, 64'd42, 1'b0, 0);

    // Back-to-back: second accepted in the first's done cycle.
    @(negedge clk);
    do_mult(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001, 1'b1, 0);
    do_mult(32'd2, 32'hFFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencer for the execute-stage multiplier that borrows the shared ALU. Runs an iterative shift-and-add multiply (signed or unsigned) through the ALU adder, owns the ALU input mux while busy, holds the HI/LO result registers, and tells the hazard unit to stall the front of the pipeline. Sits beside the ALU in the execute stage; the hazard unit consumes its stall output.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- MULT_CYCLES, WIDTH, number of RUN iterations; fixed equal to WIDTH

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MultStartE  in  1  mult/multu instruction valid in E this cycle
- MultSgnE  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with MultStartE
- FlushE  in  1  E-stage flush from hazard unit
- SrcAE, SrcBE  in  WIDTH  forwarded operands (multiplicand, multiplier)
- ALUOut  in  WIDTH  shared ALU result
- MfSelE  in  1  1 = read HI, 0 = read LO
- ALUGrant  out  1  1 = ALU inputs driven by this block
- ALU_A, ALU_B  out  WIDTH  ALU operands when granted
- ALUCtrlMult  out  3  ALU function when granted, constant ADD (3'b010)
- HiLoOutE  out  WIDTH  MfSelE ? HI : LO, combinational
- StallMultE  out  1  stall F/D/E, bubble M
- MultDoneE  out  1  one-cycle pulse: HI/LO just updated

## Operation
- States: IDLE, RUN, FIX. Reset -> IDLE.
- IDLE: if MultStartE & ~FlushE: latch M = |SrcAE| (if signed, else SrcAE), P_hi = 0, P_lo = |SrcBE| (likewise), neg = MultSgnE & (SrcAE[W-1] ^ SrcBE[W-1]), count = 0; -> RUN. Otherwise stay.
- |x| for signed = two's-complement negate when x[W-1]=1; 0x80000000 maps to unsigned 0x80000000 (correct).
- RUN: ALU_A = P_hi, ALU_B = P_lo[0] ? M : 0. carry = (ALUOut < P_hi), unsigned compare. Update {P_hi,P_lo} <= {carry, ALUOut, P_lo[W-1:1]} (64-bit right shift with carry in). count++; after iteration MULT_CYCLES-1 -> FIX.
- FIX: {HI,LO} <= neg ? -{P_hi,P_lo} (64-bit negate, local logic, not ALU) : {P_hi,P_lo}; -> IDLE; MultDoneE registered high in next cycle.
- ALUGrant = (state == RUN). Outside RUN, ALU_A/ALU_B = 0.
- StallMultE = (state == RUN) | (state == FIX), combinational from state.
- MultStartE while not IDLE: ignored (cannot occur under correct stalling).
- FlushE while RUN/FIX: ignored; the accepted multiply is committed.
- HI/LO change only on the FIX edge or reset; mfhi/mflo in IDLE reads the latest result.

## Timing
- Reset values: state IDLE, HI = LO = 0, P/M/count/neg = 0, ALUGrant = 0, ALU_A = ALU_B = 0, StallMultE = 0, MultDoneE = 0; HiLoOutE = 0.
- Accept at cycle T (StallMultE low in T; the mult instruction leaves E at the end of T).
- RUN in T+1 .. T+WIDTH; FIX in T+WIDTH+1; StallMultE high T+1 .. T+WIDTH+1 (33 cycles for WIDTH = 32).
- HI/LO valid from T+WIDTH+2; MultDoneE high exactly in T+WIDTH+2. Back-to-back mult may be accepted in T+WIDTH+2.
- rst mid-operation: immediately IDLE, HI/LO cleared, stall and grant drop asynchronously, no MultDoneE.

## Structure
- Shared package: state enum (IDLE/RUN/FIX), ALU_ADD = 3'b010, MULT_CYCLES, count width $clog2(MULT_CYCLES).
- One sub-module is natural: mult_signfix (operand magnitude and 64-bit conditional negate, combinational).
- Bench supplies a behavioural ALU (y = a + b for ADD) on ALU_A/ALU_B/ALUOut.

## Test plan
- multu 0xFFFFFFFF * 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; MultDoneE at T+34; StallMultE high exactly T+1..T+33.
- mult -3 * 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; mult -1 * -1 -> HI = 0, LO = 1.
- mult 0x80000000 * 0x80000000 -> HI = 0x40000000, LO = 0; mult 0x80000000 * 1 -> HI = 0xFFFFFFFF, LO = 0x80000000.
- MultStartE with FlushE = 1 in IDLE -> no start, StallMultE stays 0, HI/LO unchanged; FlushE pulsed during RUN -> result still written.
- rst asserted at T+10 of a multiply -> state IDLE, HI = LO = 0, StallMultE = 0, no MultDoneE; a new multu 7 * 6 afterwards -> LO = 42, HI = 0.
- Back-to-back: second multu accepted at T+34 -> first result readable via HiLoOutE (MfSelE toggled) during T+34, second MultDoneE at T+68.
